shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_step.sv | 16 +
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and default sizing for the shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/shift_step.sv
// One-bit shifter: left fills LSB with 0, right fills MSB with fill_i.
module shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             dir_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    if (dir_i) value_o = {value_i[WIDTH-2:0], 1'b0};
    else       value_o = {fill_i, value_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter, one bit per clock. Define SHIFT_ARITH_EN to add the
// arith input for sign-replicating right shifts.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] shamt,
  input  logic [WIDTH-1:0] data_in,
`ifdef SHIFT_ARITH_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output state_e           state_o
);

  // Handshake: start is sampled only while busy=0; operands are captured on
  // that edge. done pulses for one cycle on the same cycle data_out updates,
  // which is also the first cycle busy is low again.

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               fill;
  logic [WIDTH-1:0]   step_out;

`ifdef SHIFT_ARITH_EN
  logic arith_q, arith_d;
  assign fill = arith_q & work_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i (work_q),
    .dir_i   (dir_q),
    .fill_i  (fill),
    .value_o (step_out)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dir_d      = dir_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
`ifdef SHIFT_ARITH_EN
    arith_d    = arith_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          cnt_d   = shamt;
          dir_d   = dir;
`ifdef SHIFT_ARITH_EN
          arith_d = arith;
`endif
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        // Result and pulse are registered so data_out never shows partial shifts.
        data_out_d = work_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      data_out_q <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef SHIFT_ARITH_EN
      arith_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
`ifdef SHIFT_ARITH_EN
      arith_q    <= arith_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; arith vectors run when SHIFT_ARITH_EN is defined.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic [2:0] shamt;
  logic [7:0] data_in;
`ifdef SHIFT_ARITH_EN
  logic       arith;
`endif
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  state_e     state_o;

  int         n_cmp;
  int         n_err;
  logic [7:0] prev_out;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .shamt    (shamt),
    .data_in  (data_in),
`ifdef SHIFT_ARITH_EN
    .arith    (arith),
`endif
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .state_o  (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: start sampled at edge E0, expect done sh+1 edges later.
  task automatic run_op(input logic [7:0] din, input logic [2:0] sh, input logic d,
                        input logic a, input logic [7:0] exp, input string tag);
    int    edges;
    int    busy_cyc;
    string t;
    t = $sformatf("%s%s", tag, a ? "_arith" : "");
    @(negedge clk);
    start = 1'b1; data_in = din; shamt = sh; dir = d;
`ifdef SHIFT_ARITH_EN
    arith = a;
`endif
    @(posedge clk);
    edges = 0; busy_cyc = 0;
    @(negedge clk);
    start = 1'b0;
    data_in = 8'($urandom_range(0, 255));
    shamt = 3'($urandom_range(0, 7));
    dir = ~d;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      check({t, "_hold"}, data_out, prev_out);
      @(posedge clk); edges++;
      @(negedge clk);
    end
    check({t, "_latency"}, edges, sh + 1);
    check({t, "_busy_cycles"}, busy_cyc, sh + 1);
    check({t, "_data"}, data_out, exp);
    check({t, "_busy_at_done"}, busy, 1'b0);
    prev_out = exp;
    @(negedge clk);
    check({t, "_done_width"}, done, 1'b0);
  endtask

  initial begin
    int done_cnt;
    int done_edge;
    n_cmp = 0; n_err = 0; prev_out = 8'h00;
    rst = 1'b1; start = 1'b0; dir = 1'b0; shamt = '0; data_in = '0;
`ifdef SHIFT_ARITH_EN
    arith = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", state_o, IDLE);
    rst = 1'b0;

    run_op(8'hB4, 3'd3, 1'b0, 1'b0, 8'h16, "b4_r3");
    run_op(8'h81, 3'd1, 1'b1, 1'b0, 8'h02, "81_l1");
    run_op(8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, "5a_0");
    run_op(8'h01, 3'd7, 1'b1, 1'b0, 8'h80, "01_l7");
    run_op(8'hC3, 3'd2, 1'b1, 1'b0, 8'h0C, "c3_l2");
`ifdef SHIFT_ARITH_EN
    run_op(8'hB4, 3'd3, 1'b0, 1'b1, 8'hF6, "b4_r3");
    run_op(8'h34, 3'd3, 1'b0, 1'b1, 8'h06, "34_r3");
    run_op(8'h81, 3'd1, 1'b1, 1'b1, 8'h02, "81_l1");
`endif

    // start pulses at edges 2 and 5 while busy must be ignored
    @(negedge clk);
    start = 1'b1; data_in = 8'hFF; shamt = 3'd7; dir = 1'b0;
`ifdef SHIFT_ARITH_EN
    arith = 1'b0;
`endif
    @(posedge clk);
    done_cnt = 0; done_edge = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5);
      data_in = 8'h00; shamt = 3'd1; dir = 1'b1;
      if (done) done_cnt++;
      @(posedge clk);
      #1;
      if (done && done_edge == 0) done_edge = k;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_start_done_count", done_cnt + (done_edge != 0 ? 1 : 0) - (done_cnt > 0 ? 1 : 0), 1);
    check("busy_start_done_edge", done_edge, 8);
    check("busy_start_data", data_out, 8'h01);
    prev_out = 8'h01;
    repeat (2) @(negedge clk);

    // reset mid-operation abandons it
    @(negedge clk);
    start = 1'b1; data_in = 8'hF0; shamt = 3'd5; dir = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_data", data_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_state", state_o, IDLE);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    prev_out = 8'h00;
    run_op(8'h80, 3'd2, 1'b0, 1'b0, 8'h20, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
